// File: rtl/kbd_vp1_014.sv
// kbd_vp1_014 - K1801VP1-014 keyboard controller on the inverted multiplexed bus.
// Holds decoded key codes and exposes them through two registers:
//   177660 status: bit 7 DONE (code available), bit 6 MASK (interrupt disable).
//   177662 data:   {9'b0, code[6:0]}; a read pops the held code.
// A vectored interrupt (060, or 274 when AR2 was held) is requested while a code
// is pending and the mask is clear.
// Optional feature macro: KBD_FIFO_EN selects a FIFO_DEPTH-entry key FIFO instead
// of the single holding register of the original chip.
// Ports:
//   pin_clk, pin_rst          clock, synchronous active-high reset (also bus init)
//   pin_ad_n                  inverted address/data bus, driven only when replying
//   pin_sync_n, pin_din_n,
//   pin_dout_n, pin_wtbt_n,
//   pin_iako_n                bus strobes and status
//   pin_rply_n, pin_virq_n    open-drain reply and vectored interrupt request
//   key_code, key_ar2,
//   key_strobe, key_down      key matrix scanner interface
//   pin_key_n                 registered inverted key_down for system port bit 6
module kbd_vp1_014 #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  inout  wire  [15:0] pin_ad_n,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  input  logic        pin_iako_n,
  output wire         pin_rply_n,
  output wire         pin_virq_n,
  input  logic [6:0]  key_code,
  input  logic        key_ar2,
  input  logic        key_strobe,
  input  logic        key_down,
  output logic        pin_key_n
);

  localparam logic [15:0] ADDR_ST = 16'o177660;
  localparam logic [15:0] ADDR_DT = 16'o177662;
  localparam logic [15:0] VEC_STD = 16'o000060;
  localparam logic [15:0] VEC_AR2 = 16'o000274;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACT, S_REPLY} state_t;
  typedef enum logic [2:0] {OP_RD_ST, OP_RD_DT, OP_WR_ST, OP_WR_DT, OP_IAK} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic        sync_prev_q;
  logic        addr0_q;
  logic        sel_st_q, sel_dt_q;
  logic        rply_q, rply_d;
  logic        drv_q, drv_d;
  logic [15:0] dout_q, dout_d;
  logic        wbit_q, wbit_d;
  logic        wbyte_q, wbyte_d;
  logic        mask_q, taken_q, virq_q;
  logic        pop_c, mask_we_c, take_c;
  logic        done_w;
  logic [7:0]  head_w;
  logic [15:0] bus_in;
  logic        req_w;
  logic        is_wr_w;
  logic        strobe_hi_w;

  assign bus_in      = ~pin_ad_n;
  assign req_w       = done_w & ~mask_q & ~taken_q;
  assign is_wr_w     = (op_q == OP_WR_ST) || (op_q == OP_WR_DT);
  assign strobe_hi_w = is_wr_w ? pin_dout_n : pin_din_n;

  // Address phase: decode on the falling edge of sync, hold until sync rises
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      sync_prev_q <= 1'b1;
      addr0_q     <= 1'b0;
      sel_st_q    <= 1'b0;
      sel_dt_q    <= 1'b0;
    end else begin
      sync_prev_q <= pin_sync_n;
      if (sync_prev_q && !pin_sync_n) begin
        addr0_q  <= bus_in[0];
        sel_st_q <= (bus_in[15:1] == ADDR_ST[15:1]);
        sel_dt_q <= (bus_in[15:1] == ADDR_DT[15:1]);
      end else if (pin_sync_n) begin
        sel_st_q <= 1'b0;
        sel_dt_q <= 1'b0;
      end
    end
  end

  // Bus state register
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD_ST;
      rply_q  <= 1'b0;
      drv_q   <= 1'b0;
      dout_q  <= '1;
      wbit_q  <= 1'b0;
      wbyte_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rply_q  <= rply_d;
      drv_q   <= drv_d;
      dout_q  <= dout_d;
      wbit_q  <= wbit_d;
      wbyte_q <= wbyte_d;
    end
  end

  // Bus next-state; side effects fire on the strobe-release edge only
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rply_d    = rply_q;
    drv_d     = drv_q;
    dout_d    = dout_q;
    wbit_d    = wbit_q;
    wbyte_d   = wbyte_q;
    pop_c     = 1'b0;
    mask_we_c = 1'b0;
    take_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!pin_iako_n && !pin_din_n && req_w) begin
          op_d    = OP_IAK;
          state_d = S_ACT;
        end else if ((sel_st_q || sel_dt_q) && !pin_din_n) begin
          op_d    = sel_st_q ? OP_RD_ST : OP_RD_DT;
          state_d = S_ACT;
        end else if ((sel_st_q || sel_dt_q) && !pin_dout_n) begin
          op_d    = sel_st_q ? OP_WR_ST : OP_WR_DT;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        state_d = S_REPLY;
        rply_d  = 1'b1;
        drv_d   = !is_wr_w;
        wbit_d  = bus_in[6];
        wbyte_d = !pin_wtbt_n;
        unique case (op_q)
          OP_RD_ST: dout_d = ~{8'b0, done_w, mask_q, 6'b0};
          OP_RD_DT: dout_d = ~{9'b0, head_w[6:0]};
          OP_IAK:   dout_d = ~(head_w[7] ? VEC_AR2 : VEC_STD);
          default:  dout_d = '1;
        endcase
      end
      S_REPLY: begin
        if (strobe_hi_w) begin
          state_d   = S_IDLE;
          rply_d    = 1'b0;
          drv_d     = 1'b0;
          pop_c     = (op_q == OP_RD_DT);
          mask_we_c = (op_q == OP_WR_ST) && (!wbyte_q || !addr0_q);
          take_c    = (op_q == OP_IAK);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef KBD_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          push_w, pop_w;

  assign done_w = (cnt_q != '0);
  assign head_w = mem_q[rp_q];
  assign push_w = key_strobe && (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign pop_w  = pop_c && done_w;

  // Key storage; pointers wrap naturally since the depth is a power of two
  always_ff @(posedge pin_clk) begin
    if (push_w) mem_q[wp_q] <= {key_ar2, key_code};
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_w) wp_q <= wp_q + AW'(1);
      if (pop_w)  rp_q <= rp_q + AW'(1);
      if (push_w && !pop_w)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop_w && !push_w) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end
`else
  logic [7:0] hold_q;
  logic       done_q;
  logic       load_w;

  // Single holding register: a new key is taken only if empty or being popped
  assign load_w = key_strobe && (!done_q || pop_c);
  assign done_w = done_q;
  assign head_w = hold_q;

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      hold_q <= '0;
      done_q <= 1'b0;
    end else if (load_w) begin
      hold_q <= {key_ar2, key_code};
      done_q <= 1'b1;
    end else if (pop_c) begin
      done_q <= 1'b0;
    end
  end
`endif

  // Mask, vector-taken flag, interrupt request and key-held output
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      mask_q    <= 1'b0;
      taken_q   <= 1'b0;
      virq_q    <= 1'b0;
      pin_key_n <= 1'b1;
    end else begin
      if (mask_we_c) mask_q <= wbit_q;
      if (!done_w)     taken_q <= 1'b0;
      else if (take_c) taken_q <= 1'b1;
      virq_q    <= req_w;
      pin_key_n <= ~key_down;
    end
  end

  assign pin_rply_n = rply_q ? 1'b0 : 1'bz;
  assign pin_virq_n = virq_q ? 1'b0 : 1'bz;
  assign pin_ad_n   = drv_q ? dout_q : 16'bz;

endmodule
